scanchain_writer: RTL and testbench

Serialises one scan write command into the chip's scan-chain pins. Sits directly downstream of the UART scan client: consumes its `write_valid/write_ready/write_addr/write_payload/write_reset` handshake and drives the on-chip scan interface (`scan_clk`, `scan_en`, `scan_in`, `scan_update`, `scan_reset`) at a divided rate. It returns `write_ready` only when the chip-side transaction has fully completed.

---
 rtl/scanchain_pkg.sv | 20 ++
 rtl/scan_clk_div.sv | 39 +++
 rtl/scanchain_writer.sv | 116 +++++++++++
 tb/tb_scanchain_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/scanchain_pkg.sv
// Shared scan-chain definitions: the writer FSM state encoding and the
// default address/payload widths also used by the UART scan client.
package scanchain_pkg;

  localparam int SCAN_ADDR_BITS    = 12;
  localparam int SCAN_PAYLOAD_BITS = 169;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    RST    = 2'd3
  } scan_state_e;

  // A divide-by-1 still needs a one-bit counter so the ports stay legal.
  function automatic int div_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/scan_clk_div.sv
// Scan clock divider: counts CLK_DIV system cycles per half period and
// toggles a phase bit at the end of each half; restarts low on clear.
module scan_clk_div
  import scanchain_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tick,
  output logic phase
);

  localparam int DW = div_cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_reg;
  logic          phase_reg;

  assign half_tick = (div_cnt_reg == DIV_LAST);
  assign phase     = phase_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
    end else if (clear) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
    end else if (half_tick) begin
      div_cnt_reg <= '0;
      phase_reg   <= ~phase_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/scanchain_writer.sv
// Serialises one scan write (or chain reset) command onto the chip scan pins
// at a divided rate; write_ready returns only once the chip-side frame ends.
module scanchain_writer
  import scanchain_pkg::*;
#(
  parameter int ADDR_BITS    = SCAN_ADDR_BITS,
  parameter int PAYLOAD_BITS = SCAN_PAYLOAD_BITS,
  parameter int CLK_DIV      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic [ADDR_BITS-1:0]    write_addr,
  input  logic [PAYLOAD_BITS-1:0] write_payload,
  input  logic                    write_reset,
  output logic                    scan_clk,
  output logic                    scan_en,
  output logic                    scan_in,
  output logic                    scan_update,
  output logic                    scan_reset
);

  localparam int N  = ADDR_BITS + PAYLOAD_BITS;
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
  localparam logic [1:0] S_UPDATE = UPDATE;
  localparam logic [1:0] S_RST    = RST;

  logic [1:0]    state_reg, state_next;
  logic [N-1:0]  shreg_reg, shreg_next;
  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
  logic          ready_reg;
  logic          scan_clk_reg, scan_en_reg, scan_in_reg;
  logic          scan_update_reg, scan_reset_reg;
  logic          half_tick, phase, clear, period_end;

  scan_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .half_tick (half_tick),
    .phase     (phase)
  );

  // A scan period ends on the last cycle of its high half.
  assign period_end = half_tick & phase;

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (write_valid && ready_reg) begin
          if (write_reset) begin
            state_next = S_RST;
          end else begin
            state_next = S_SHIFT;
            shreg_next = {write_addr, write_payload};
          end
        end
      end
      S_SHIFT: begin
        if (period_end) begin
          shreg_next = {shreg_reg[N-2:0], 1'b0};
          if (bit_cnt_reg == '0) state_next = S_UPDATE;
          else                   bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      S_UPDATE, S_RST: begin
        if (period_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next != state_reg) bit_cnt_next = (state_next == S_SHIFT) ? BIT_LAST : '0;
    clear = (state_next != state_reg) || (state_reg == S_IDLE);
  end

  // Outputs are registered from the next-state values so they line up with
  // the state register and never decode through combinational logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      shreg_reg       <= '0;
      bit_cnt_reg     <= '0;
      ready_reg       <= 1'b1;
      scan_clk_reg    <= 1'b0;
      scan_en_reg     <= 1'b0;
      scan_in_reg     <= 1'b0;
      scan_update_reg <= 1'b0;
      scan_reset_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shreg_reg       <= shreg_next;
      bit_cnt_reg     <= bit_cnt_next;
      ready_reg       <= (state_next == S_IDLE);
      scan_clk_reg    <= (state_next == S_SHIFT) && !clear && (phase ^ half_tick);
      scan_en_reg     <= (state_next == S_SHIFT);
      scan_in_reg     <= (state_next == S_SHIFT) ? shreg_next[N-1] : 1'b0;
      scan_update_reg <= (state_next == S_UPDATE);
      scan_reset_reg  <= (state_next == S_RST);
    end
  end

  assign write_ready = ready_reg;
  assign scan_clk    = scan_clk_reg;
  assign scan_en     = scan_en_reg;
  assign scan_in     = scan_in_reg;
  assign scan_update = scan_update_reg;
  assign scan_reset  = scan_reset_reg;

endmodule

// File: tb/tb_scanchain_writer.sv
// Directed bench for scanchain_writer: a vector table of single frames plus
// hand-written reset, busy-drop, back-to-back and divide-by-1 sequences.
module tb_scanchain_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [3:0] write_addr = '0;
  logic [7:0] write_payload = '0;
  logic       write_reset = 1'b0;

  logic ready0, sclk0, sen0, sin0, supd0, srst0;
  logic ready1, sclk1, sen1, sin1, supd1, srst1;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scanchain_writer #(.ADDR_BITS(4), .PAYLOAD_BITS(8), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(rst_n), .write_valid(valid0), .write_ready(ready0),
    .write_addr(write_addr), .write_payload(write_payload), .write_reset(write_reset),
    .scan_clk(sclk0), .scan_en(sen0), .scan_in(sin0), .scan_update(supd0), .scan_reset(srst0)
  );

  scanchain_writer #(.ADDR_BITS(4), .PAYLOAD_BITS(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(rst_n), .write_valid(valid1), .write_ready(ready1),
    .write_addr(write_addr), .write_payload(write_payload), .write_reset(write_reset),
    .scan_clk(sclk1), .scan_en(sen1), .scan_in(sin1), .scan_update(supd1), .scan_reset(srst1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issues one command and watches the chosen DUT until write_ready returns.
  // Cycle j is sampled on the falling edge after accept edge k + (j-1).
  task automatic run_frame(input bit which, input bit rc, input logic [3:0] a,
                           input logic [7:0] p, input int drop_at,
                           output logic [11:0] bits, output int rises, output int lat,
                           output int en_cnt, output int upd_cnt, output int rst_cnt,
                           output int first_en, output int first_in, output int first_rise,
                           output int ready_j1, output int clk_bad);
    logic c, e, i, u, r, rdy, prev;
    bits = '0; rises = 0; lat = -1; en_cnt = 0; upd_cnt = 0; rst_cnt = 0;
    first_en = -1; first_in = -1; first_rise = -1; ready_j1 = -1; clk_bad = 0;
    prev = 1'b0;
    @(negedge clk);
    write_addr = a; write_payload = p; write_reset = rc;
    if (which) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (j == 1) begin valid0 = 1'b0; valid1 = 1'b0; end
      if (drop_at > 0 && j == drop_at) begin
        write_addr = 4'h3; write_payload = 8'h81; write_reset = 1'b0; valid0 = 1'b1;
      end
      if (drop_at > 0 && j == drop_at + 1) valid0 = 1'b0;
      c   = which ? sclk1  : sclk0;
      e   = which ? sen1   : sen0;
      i   = which ? sin1   : sin0;
      u   = which ? supd1  : supd0;
      r   = which ? srst1  : srst0;
      rdy = which ? ready1 : ready0;
      if (j == 1) begin first_en = e; first_in = i; ready_j1 = rdy; end
      if (rdy) begin lat = j; break; end
      en_cnt += e; upd_cnt += u; rst_cnt += r;
      if (c && !prev) begin
        rises++;
        bits = {bits[10:0], i};
        if (first_rise < 0) first_rise = j;
      end
      if (which && e && (c != (j % 2 == 0))) clk_bad++;
      if (!which && c && !e) clk_bad++;
      prev = c;
    end
  endtask

  typedef struct {
    logic        rc;
    logic [3:0]  a;
    logic [7:0]  p;
    logic [11:0] exp_bits;
    int          exp_rises;
    int          exp_lat;
    int          exp_en;
    int          exp_upd;
    int          exp_rst;
    int          exp_first_rise;
    int          exp_first_in;
    int          exp_first_en;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bits;
    int rises, lat, en_cnt, upd_cnt, rst_cnt, f_en, f_in, f_rise, rdy1, clk_bad;
    int first_ready, second_ready, ready_ones, en_after, upd_seen, busy_seen;

    vecs[0] = '{1'b0, 4'hA, 8'h5C, 12'hA5C, 12, 53, 48, 4, 0,  3, 1, 1};
    vecs[1] = '{1'b0, 4'h3, 8'h81, 12'h381, 12, 53, 48, 4, 0,  3, 0, 1};
    vecs[2] = '{1'b0, 4'hF, 8'hFF, 12'hFFF, 12, 53, 48, 4, 0,  3, 1, 1};
    vecs[3] = '{1'b0, 4'h0, 8'h00, 12'h000, 12, 53, 48, 4, 0,  3, 0, 1};
    vecs[4] = '{1'b1, 4'h7, 8'h3C, 12'h000,  0,  5,  0, 0, 4, -1, 0, 0};

    // Reset state while reset is held low.
    repeat (3) @(negedge clk);
    check("reset_outputs_dut0", int'({sclk0, sen0, sin0, supd0, srst0, ready0}), 1);
    check("reset_outputs_dut1", int'({sclk1, sen1, sin1, supd1, srst1, ready1}), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_frame(1'b0, vecs[v].rc, vecs[v].a, vecs[v].p, 0, bits, rises, lat, en_cnt,
                upd_cnt, rst_cnt, f_en, f_in, f_rise, rdy1, clk_bad);
      $display("vec %0d: rc=%0d addr=%h payload=%h bits=%h rises=%0d ready_after=%0d en=%0d upd=%0d rst=%0d",
               v, vecs[v].rc, vecs[v].a, vecs[v].p, bits, rises, lat, en_cnt, upd_cnt, rst_cnt);
      check($sformatf("vec%0d_bits", v), int'(bits), int'(vecs[v].exp_bits));
      check($sformatf("vec%0d_rises", v), rises, vecs[v].exp_rises);
      check($sformatf("vec%0d_ready_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_scan_en_cycles", v), en_cnt, vecs[v].exp_en);
      check($sformatf("vec%0d_update_cycles", v), upd_cnt, vecs[v].exp_upd);
      check($sformatf("vec%0d_reset_cycles", v), rst_cnt, vecs[v].exp_rst);
      check($sformatf("vec%0d_first_rise", v), f_rise, vecs[v].exp_first_rise);
      check($sformatf("vec%0d_first_scan_in", v), f_in, vecs[v].exp_first_in);
      check($sformatf("vec%0d_first_scan_en", v), f_en, vecs[v].exp_first_en);
      check($sformatf("vec%0d_ready_low_after_accept", v), rdy1, 0);
      check($sformatf("vec%0d_clk_outside_shift", v), clk_bad, 0);
    end

    // Busy drop: a second command mid-shift must not alter the frame.
    run_frame(1'b0, 1'b0, 4'hA, 8'h5C, 10, bits, rises, lat, en_cnt,
              upd_cnt, rst_cnt, f_en, f_in, f_rise, rdy1, clk_bad);
    $display("busy_drop: bits=%h ready_after=%0d upd=%0d", bits, lat, upd_cnt);
    check("busy_drop_bits", int'(bits), 12'hA5C);
    check("busy_drop_ready_latency", lat, 53);
    check("busy_drop_update_cycles", upd_cnt, 4);
    en_after = 0;
    repeat (6) begin @(negedge clk); en_after += sen0; end
    check("busy_drop_no_second_frame", en_after, 0);

    // Back-to-back: valid held high, frames separated by one IDLE cycle.
    @(negedge clk);
    write_addr = 4'hA; write_payload = 8'h5C; write_reset = 1'b0; valid0 = 1'b1;
    @(posedge clk);
    first_ready = -1; second_ready = -1; ready_ones = 0; en_after = -1;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (first_ready > 0 && j == first_ready + 1) begin en_after = sen0; valid0 = 1'b0; end
      if (ready0) begin
        if (first_ready < 0) first_ready = j;
        else if (j > first_ready + 1) begin second_ready = j; break; end
        ready_ones++;
      end
    end
    $display("back_to_back: first_ready=%0d second_ready=%0d idle_cycles=%0d", first_ready, second_ready, ready_ones);
    check("b2b_first_ready", first_ready, 53);
    check("b2b_idle_gap", ready_ones, 1);
    check("b2b_second_started", en_after, 1);
    check("b2b_second_ready", second_ready, 106);

    // Reset mid-shift: outputs clear asynchronously and no update follows.
    @(negedge clk);
    write_addr = 4'hA; write_payload = 8'h5C; valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk); valid0 = 1'b0;
    repeat (19) @(negedge clk);
    check("midreset_was_shifting", int'(sen0), 1);
    #2 rst_n = 1'b0;
    #1 check("midreset_async_outputs", int'({sclk0, sen0, sin0, supd0, srst0, ready0}), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    upd_seen = 0; busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      upd_seen += supd0;
      if ({sclk0, sen0, sin0, srst0} != 4'b0 || !ready0) busy_seen++;
    end
    $display("mid_reset: update_cycles=%0d busy_cycles=%0d", upd_seen, busy_seen);
    check("midreset_no_update", upd_seen, 0);
    check("midreset_idle_after", busy_seen, 0);

    // Divide-by-1: scan clock toggles every cycle.
    run_frame(1'b1, 1'b0, 4'hA, 8'h5C, 0, bits, rises, lat, en_cnt,
              upd_cnt, rst_cnt, f_en, f_in, f_rise, rdy1, clk_bad);
    $display("clkdiv1: bits=%h ready_after=%0d en=%0d upd=%0d first_rise=%0d", bits, lat, en_cnt, upd_cnt, f_rise);
    check("div1_bits", int'(bits), 12'hA5C);
    check("div1_ready_latency", lat, 27);
    check("div1_toggle_errors", clk_bad, 0);
    check("div1_scan_en_cycles", en_cnt, 24);
    check("div1_update_cycles", upd_cnt, 2);
    check("div1_first_rise", f_rise, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
